// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: 8N1 UART receiver with its own fractional tick generator at Baud*Oversampling.
// Optional parity bit (ParityOdd, rx_parity_err) is enabled by defining UART_RX_PARITY_EN.
module uart_rx_oversampled #(
   parameter int ClkFrequency = 66000000,
   parameter int Baud         = 9600,
   parameter int Oversampling = 8
`ifdef UART_RX_PARITY_EN
   ,parameter int ParityOdd   = 0
`endif
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_data_ready,
   output logic       rx_framing_err,
`ifdef UART_RX_PARITY_EN
   output logic       rx_parity_err,
`endif
   output logic       rx_idle
);

   function automatic int log2(input int v);
      int n;
      n = 0;
      while ((v >> n) != 0) n = n + 1;
      return n;
   endfunction

   // ShiftLimiter keeps Baud*Oversampling << (AccWidth-ShiftLimiter) inside 31 bits.
   localparam int AccWidth     = log2(ClkFrequency / Baud) + 8;
   localparam int ShiftLimiter = log2((Baud * Oversampling) >> (31 - AccWidth));
   localparam int Inc          = ((Baud * Oversampling << (AccWidth - ShiftLimiter))
                                  + (ClkFrequency >> (ShiftLimiter + 1)))
                                 / (ClkFrequency >> ShiftLimiter);
   localparam logic [AccWidth:0] IncVec = (AccWidth + 1)'(Inc);

   localparam int OsW = $clog2(Oversampling);
   localparam logic [OsW-1:0] OsLast = OsW'(Oversampling - 1);
   localparam logic [OsW-1:0] OsHalf = OsW'(Oversampling / 2 - 1);
   localparam logic [OsW-1:0] OsOne  = OsW'(1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, STOP, WAIT_HIGH
`ifdef UART_RX_PARITY_EN
      , PARITY
`endif
   } state_t;

   logic [AccWidth:0] acc_reg;
   logic              tick;
   logic [1:0]        sync_reg;
   logic [1:0]        hist_reg;
   logic              filt_reg;
   logic              line;

   state_t            state_reg, state_next;
   logic [OsW-1:0]    os_reg, os_next;
   logic [2:0]        bit_reg, bit_next;
   logic [7:0]        shift_reg, shift_next;
   logic [7:0]        data_reg, data_next;
   logic              ready_reg, ready_next;
   logic              ferr_reg, ferr_next;
`ifdef UART_RX_PARITY_EN
   logic              par_bit_reg, par_bit_next;
   logic              perr_reg, perr_next;
   logic              par_bad;
`endif

   assign tick = acc_reg[AccWidth];
   assign line = sync_reg[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg  <= '0;
         sync_reg <= 2'b11;
         hist_reg <= 2'b11;
         filt_reg <= 1'b1;
      end else begin
         acc_reg  <= {1'b0, acc_reg[AccWidth-1:0]} + IncVec;
         sync_reg <= {sync_reg[0], rxd};
         if (tick) begin
            // Majority of the two previous tick samples and the current one.
            hist_reg <= {hist_reg[0], line};
            filt_reg <= (hist_reg[1] & hist_reg[0]) | (hist_reg[1] & line) | (hist_reg[0] & line);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         os_reg      <= '0;
         bit_reg     <= '0;
         shift_reg   <= '0;
         data_reg    <= '0;
         ready_reg   <= 1'b0;
         ferr_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit_reg <= 1'b0;
         perr_reg    <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         os_reg      <= os_next;
         bit_reg     <= bit_next;
         shift_reg   <= shift_next;
         data_reg    <= data_next;
         ready_reg   <= ready_next;
         ferr_reg    <= ferr_next;
`ifdef UART_RX_PARITY_EN
         par_bit_reg <= par_bit_next;
         perr_reg    <= perr_next;
`endif
      end
   end

`ifdef UART_RX_PARITY_EN
   assign par_bad = ((^shift_reg) ^ par_bit_reg) != ParityOdd[0];
`endif

   always_comb begin
      state_next = state_reg;
      os_next    = os_reg;
      bit_next   = bit_reg;
      shift_next = shift_reg;
      data_next  = data_reg;
      ready_next = 1'b0;
      ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_next = par_bit_reg;
      perr_next    = 1'b0;
`endif
      if (tick) begin
         case (state_reg)
            IDLE: begin
               if (!filt_reg) begin
                  state_next = START;
                  os_next    = '0;
               end
            end
            START: begin
               if (os_reg == OsHalf) begin
                  if (filt_reg) begin
                     state_next = IDLE;
                  end else begin
                     os_next    = '0;
                     bit_next   = '0;
                     state_next = DATA;
                  end
               end else begin
                  os_next = os_reg + OsOne;
               end
            end
            DATA: begin
               if (os_reg == OsLast) begin
                  shift_next[bit_reg] = filt_reg;
                  os_next  = '0;
                  bit_next = bit_reg + 3'd1;
                  if (bit_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_next = PARITY;
`else
                     state_next = STOP;
`endif
                  end
               end else begin
                  os_next = os_reg + OsOne;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (os_reg == OsLast) begin
                  par_bit_next = filt_reg;
                  os_next      = '0;
                  state_next   = STOP;
               end else begin
                  os_next = os_reg + OsOne;
               end
            end
`endif
            STOP: begin
               if (os_reg == OsLast) begin
                  os_next = '0;
                  if (filt_reg) begin
                     state_next = IDLE;
`ifdef UART_RX_PARITY_EN
                     if (par_bad) begin
                        perr_next = 1'b1;
                     end else begin
                        data_next  = shift_reg;
                        ready_next = 1'b1;
                     end
`else
                     data_next  = shift_reg;
                     ready_next = 1'b1;
`endif
                  end else begin
                     // Low stop bit: report once, then wait out any break.
                     ferr_next  = 1'b1;
                     state_next = WAIT_HIGH;
                  end
               end else begin
                  os_next = os_reg + OsOne;
               end
            end
            WAIT_HIGH: begin
               if (filt_reg) state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign rx_data        = data_reg;
   assign rx_data_ready  = ready_reg;
   assign rx_framing_err = ferr_reg;
`ifdef UART_RX_PARITY_EN
   assign rx_parity_err  = perr_reg;
`endif
   assign rx_idle        = (state_reg == IDLE);

endmodule
